shift_loop_ctrl: RTL



---
 rtl/shift_loop_ctrl_pkg.sv | 14 +
 rtl/shift_loop_ctrl_loop_index_counter.sv | 43 ++++
 rtl/shift_loop_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/shift_loop_ctrl_pkg.sv
// Shared widths and FSM state encoding for the shift-size loop sequencer.
package shift_loop_ctrl_pkg;

  localparam int LOOP_W_DEF  = 5;
  localparam int SHAMT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_loop_ctrl_loop_index_counter.sv
// Loop index with load/clear, increment and terminal compare against the
// iteration count captured at run start.
module shift_loop_ctrl_loop_index_counter #(
  parameter int LOOP_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [LOOP_W-1:0] count_in,
  input  logic              inc,
  output logic [LOOP_W-1:0] idx,
  output logic              last
);

  logic [LOOP_W-1:0] idx_q, idx_d;
  logic [LOOP_W-1:0] count_q, count_d;

  always_comb begin
    idx_d   = idx_q;
    count_d = count_q;
    if (clear) begin
      idx_d   = '0;
      count_d = count_in;
    end else if (inc) begin
      idx_d = idx_q + LOOP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign idx = idx_q;
  // count is never 0 when this is consulted (empty runs bypass ISSUE)
  assign last = (idx_q == (count_q - LOOP_W'(1)));

endmodule

// File: rtl/shift_loop_ctrl.sv
// Steps the loop index through ShiftSize and hands each result downstream
// over valid/ready, one iteration at a time.
//
// state | meaning
// IDLE  | waiting for start
// SETUP | index stable, ShiftSize settling; capture result at end of cycle
// ISSUE | shamt presented, waiting for downstream ready
// DONE  | single-cycle done pulse
module shift_loop_ctrl
  import shift_loop_ctrl_pkg::*;
#(
  parameter int LOOP_W  = LOOP_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LOOP_W-1:0]  n_loops,
  output logic [LOOP_W-1:0]  t_loop_num,
  input  logic [SHAMT_W-1:0] shift_size_in,
  output logic [SHAMT_W-1:0] shamt,
  output logic               shamt_valid,
  input  logic               shamt_ready,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               shamt_valid_q, shamt_valid_d;
  logic               cnt_clear, cnt_inc, cnt_last;
  logic               handshake;

  assign handshake = shamt_valid_q & shamt_ready;

  shift_loop_ctrl_loop_index_counter #(.LOOP_W(LOOP_W)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .count_in (n_loops),
    .inc      (cnt_inc),
    .idx      (t_loop_num),
    .last     (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    shamt_d       = shamt_q;
    shamt_valid_d = shamt_valid_q;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = (n_loops == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        shamt_d       = shift_size_in;
        shamt_valid_d = 1'b1;
        state_d       = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (handshake) begin
          shamt_valid_d = 1'b0;
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shamt_q       <= '0;
      shamt_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shamt_q       <= shamt_d;
      shamt_valid_q <= shamt_valid_d;
    end
  end

  assign shamt       = shamt_q;
  assign shamt_valid = shamt_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule
